// File: rtl/module_operando_pkg.sv
// Shared keypad types: key classes, special key positions and entry FSM states.
package pkg_teclado;

   typedef enum logic [2:0] {
      DIGIT,
      CLEAR,
      ENTER,
      BSPC,
      NONE
   } key_kind_t;

   localparam logic [3:0] P_STAR = 4'd3;
   localparam logic [3:0] P_HASH = 4'd11;
   localparam logic [3:0] P_A    = 4'd12;

   typedef enum logic [1:0] {
      ENTRY,
      CONVERT,
      DONE
   } state_t;

endpackage

// File: rtl/module_tecla_dec.sv
// 4x4 keypad position decoder: pos = {codc, codf} -> key class and digit value.
module module_tecla_dec
   import pkg_teclado::*;
(
   input  logic [3:0] i_pos,
   output key_kind_t  o_kind,
   output logic [3:0] o_digit
);

   always_comb begin
      o_kind  = NONE;
      o_digit = 4'd0;
      case (i_pos)
         4'd0:   begin o_kind = DIGIT; o_digit = 4'd1; end
         4'd1:   begin o_kind = DIGIT; o_digit = 4'd4; end
         4'd2:   begin o_kind = DIGIT; o_digit = 4'd7; end
         4'd4:   begin o_kind = DIGIT; o_digit = 4'd2; end
         4'd5:   begin o_kind = DIGIT; o_digit = 4'd5; end
         4'd6:   begin o_kind = DIGIT; o_digit = 4'd8; end
         4'd7:   begin o_kind = DIGIT; o_digit = 4'd0; end
         4'd8:   begin o_kind = DIGIT; o_digit = 4'd3; end
         4'd9:   begin o_kind = DIGIT; o_digit = 4'd6; end
         4'd10:  begin o_kind = DIGIT; o_digit = 4'd9; end
         P_STAR: o_kind = CLEAR;
         P_HASH: o_kind = ENTER;
         P_A:    o_kind = BSPC;
         default: o_kind = NONE;
      endcase
   end

endmodule

// File: rtl/module_operando.sv
// Keypad operand entry: BCD digit accumulation, serial BCD-to-binary
// conversion and valid/ack delivery to the multiplier datapath.
module module_operando
   import pkg_teclado::*;
#(
   parameter int N_DIGITS = 2,
   parameter int OUT_W    = $clog2(10**N_DIGITS),
   parameter int LED_INV  = 1
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         key_valid_i,
   input  logic [1:0]                   key_codc_i,
   input  logic [1:0]                   key_codf_i,
   input  logic                         operand_ack_i,
   output logic [OUT_W-1:0]             operand_o,
   output logic                         operand_valid_o,
   output logic [4*N_DIGITS-1:0]        bcd_o,
   output logic [$clog2(N_DIGITS+1)-1:0] digit_count_o,
   output logic                         busy_o,
   output logic                         key_rej_o
);

   localparam int BW = 4 * N_DIGITS;
   localparam int CW = $clog2(N_DIGITS + 1);
   localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   state_t           r_state;
   logic [BW-1:0]    r_bcd;
   logic [CW-1:0]    r_cnt;
   logic [IW-1:0]    r_idx;
   logic [OUT_W-1:0] r_acc;
   logic [OUT_W-1:0] r_op;
   logic             r_valid;
   logic             r_busy;
   logic             r_rej;

   key_kind_t        w_kind;
   logic [3:0]       w_digit;
   logic [3:0]       w_cur;
   logic [OUT_W-1:0] w_acc_nx;
   logic             w_clr;

   module_tecla_dec u_dec (
      .i_pos   ({key_codc_i, key_codf_i}),
      .o_kind  (w_kind),
      .o_digit (w_digit)
   );

   // acc*10 as (acc<<3)+(acc<<1); the result always fits in OUT_W
   assign w_cur    = r_bcd[r_idx*4 +: 4];
   assign w_acc_nx = (r_acc << 3) + (r_acc << 1) + OUT_W'(w_cur);
   assign w_clr    = key_valid_i && (w_kind == CLEAR);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ENTRY;
         r_bcd   <= '0;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_acc   <= '0;
         r_op    <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_rej   <= 1'b0;
      end else begin
         r_rej <= 1'b0;
         if (w_clr) begin
            r_state <= ENTRY;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
         end else begin
            unique case (r_state)
               ENTRY: begin
                  if (key_valid_i) begin
                     case (w_kind)
                        DIGIT: begin
                           if (r_cnt < CW'(N_DIGITS)) begin
                              r_bcd <= (r_bcd << 4) | BW'(w_digit);
                              r_cnt <= r_cnt + 1'b1;
                           end else begin
                              r_rej <= 1'b1;
                           end
                        end
                        BSPC: begin
                           if (r_cnt != '0) begin
                              r_bcd <= r_bcd >> 4;
                              r_cnt <= r_cnt - 1'b1;
                           end else begin
                              r_rej <= 1'b1;
                           end
                        end
                        ENTER: begin
                           if (r_cnt != '0) begin
                              r_state <= CONVERT;
                              r_idx   <= IW'(N_DIGITS - 1);
                              r_acc   <= '0;
                              r_busy  <= 1'b1;
                           end else begin
                              r_rej <= 1'b1;
                           end
                        end
                        default: r_rej <= 1'b1;
                     endcase
                  end
               end
               CONVERT: begin
                  r_rej <= key_valid_i;
                  r_acc <= w_acc_nx;
                  r_idx <= r_idx - 1'b1;
                  if (r_idx == '0) begin
                     r_op    <= w_acc_nx;
                     r_valid <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= DONE;
                  end
               end
               DONE: begin
                  r_rej <= key_valid_i;
                  if (operand_ack_i) begin
                     r_valid <= 1'b0;
                     r_bcd   <= '0;
                     r_cnt   <= '0;
                     r_state <= ENTRY;
                  end
               end
               default: r_state <= ENTRY;
            endcase
         end
      end
   end

   assign operand_o       = r_op;
   assign operand_valid_o = r_valid;
   assign bcd_o           = (LED_INV != 0) ? ~r_bcd : r_bcd;
   assign digit_count_o   = r_cnt;
   assign busy_o          = r_busy;
   assign key_rej_o       = r_rej;

endmodule

// File: tb/tb_module_operando.sv
// Scoreboard bench for module_operando with 2-digit and 4-digit instances.
module tb_module_operando;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic kv = 1'b0;
   logic [1:0] kc = '0;
   logic [1:0] kf = '0;
   logic ack = 1'b0;
   logic sel = 1'b0;

   logic [6:0]  op2;
   logic        v2, busy2, rej2;
   logic [7:0]  bcd2;
   logic [1:0]  cnt2;
   logic [13:0] op4;
   logic        v4, busy4, rej4;
   logic [15:0] bcd4;
   logic [2:0]  cnt4;

   int checks = 0;
   int errors = 0;
   int q2[$];
   int q4[$];

   always #5 clk = ~clk;

   module_operando #(.N_DIGITS(2)) dut2 (
      .clk(clk), .rst(rst),
      .key_valid_i(kv & ~sel), .key_codc_i(kc), .key_codf_i(kf),
      .operand_ack_i(ack & ~sel),
      .operand_o(op2), .operand_valid_o(v2), .bcd_o(bcd2),
      .digit_count_o(cnt2), .busy_o(busy2), .key_rej_o(rej2)
   );

   module_operando #(.N_DIGITS(4)) dut4 (
      .clk(clk), .rst(rst),
      .key_valid_i(kv & sel), .key_codc_i(kc), .key_codf_i(kf),
      .operand_ack_i(ack & sel),
      .operand_o(op4), .operand_valid_o(v4), .bcd_o(bcd4),
      .digit_count_o(cnt4), .busy_o(busy4), .key_rej_o(rej4)
   );

   logic        o_valid, o_busy, o_rej;
   logic [15:0] o_bcd;
   logic [2:0]  o_cnt;
   logic [13:0] o_op;
   assign o_valid = sel ? v4 : v2;
   assign o_busy  = sel ? busy4 : busy2;
   assign o_rej   = sel ? rej4 : rej2;
   assign o_bcd   = sel ? bcd4 : {8'h00, bcd2};
   assign o_cnt   = sel ? cnt4 : {1'b0, cnt2};
   assign o_op    = sel ? op4 : {7'd0, op2};

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // LEDs are active low on both instances
   function automatic logic [15:0] eb(input logic [15:0] v);
      return sel ? ~v : {8'h00, ~v[7:0]};
   endfunction

   logic pv2 = 1'b0;
   logic pv4 = 1'b0;
   always @(negedge clk) begin
      int e;
      if (rst && v2 && !pv2) begin
         checks++;
         if (q2.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid2: got %0d expected none", op2);
         end else begin
            e = q2.pop_front();
            if (op2 !== 7'(e)) begin
               errors++;
               $display("FAIL operand2: got %0d expected %0d", op2, e);
            end
         end
      end
      if (rst && v4 && !pv4) begin
         checks++;
         if (q4.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid4: got %0d expected none", op4);
         end else begin
            e = q4.pop_front();
            if (op4 !== 14'(e)) begin
               errors++;
               $display("FAIL operand4: got %0d expected %0d", op4, e);
            end
         end
      end
      pv2 = v2;
      pv4 = v4;
   end

   task automatic press(input int p);
      kv = 1'b1;
      kc = p[3:2];
      kf = p[1:0];
      @(posedge clk); #1;
      kv = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic do_ack();
      ack = 1'b1;
      @(posedge clk); #1;
      ack = 1'b0;
   endtask

   task automatic wait_done(input int exp_busy);
      int c = 0;
      int k = 0;
      while (!o_valid && k < 20) begin
         if (o_busy) c++;
         k++;
         @(posedge clk); #1;
      end
      chk("busy_cycles", c, exp_busy);
      chk("valid_up", {31'd0, o_valid}, 1);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      idle(2);
      rst = 1'b1;
      idle(1);
   endtask

   initial begin
      do_reset();
      chk("rst_valid", {31'd0, o_valid}, 0);
      chk("rst_busy", {31'd0, o_busy}, 0);
      chk("rst_rej", {31'd0, o_rej}, 0);
      chk("rst_cnt", {29'd0, o_cnt}, 0);
      chk("rst_bcd", {16'd0, o_bcd}, {16'd0, eb(16'h0)});
      chk("rst_op", {18'd0, o_op}, 0);

      // 2, 6, ENTER
      press(4); press(9);
      chk("bcd_26", {16'd0, o_bcd}, {16'd0, eb(16'h26)});
      chk("cnt_26", {29'd0, o_cnt}, 2);
      q2.push_back(26);
      press(11);
      wait_done(2);
      do_ack();
      chk("ack_valid", {31'd0, o_valid}, 0);
      chk("ack_cnt", {29'd0, o_cnt}, 0);

      // overflow digit rejected
      press(10); press(10);
      chk("rej_none", {31'd0, o_rej}, 0);
      press(10);
      chk("rej_full", {31'd0, o_rej}, 1);
      chk("bcd_99", {16'd0, o_bcd}, {16'd0, eb(16'h99)});
      q2.push_back(99);
      press(11);
      wait_done(2);
      do_ack();

      // backspace
      press(0); press(1); press(12);
      chk("bcd_bs", {16'd0, o_bcd}, {16'd0, eb(16'h01)});
      chk("cnt_bs", {29'd0, o_cnt}, 1);
      q2.push_back(1);
      press(11);
      wait_done(2);
      do_ack();

      // empty enter and dead key
      press(11);
      chk("rej_enter0", {31'd0, o_rej}, 1);
      chk("busy_enter0", {31'd0, o_busy}, 0);
      press(14);
      chk("rej_pos14", {31'd0, o_rej}, 1);
      chk("cnt_pos14", {29'd0, o_cnt}, 0);
      chk("bcd_pos14", {16'd0, o_bcd}, {16'd0, eb(16'h0)});

      // clear on first convert cycle
      press(4); press(11); press(3);
      chk("abort_busy", {31'd0, o_busy}, 0);
      chk("abort_bcd", {16'd0, o_bcd}, {16'd0, eb(16'h0)});
      idle(4);
      chk("abort_valid", {31'd0, o_valid}, 0);

      // reset mid convert
      press(5); press(11);
      chk("conv_busy", {31'd0, o_busy}, 1);
      rst = 1'b0;
      idle(1);
      chk("rstc_busy", {31'd0, o_busy}, 0);
      chk("rstc_cnt", {29'd0, o_cnt}, 0);
      chk("rstc_op", {18'd0, o_op}, 0);
      chk("rstc_bcd", {16'd0, o_bcd}, {16'd0, eb(16'h0)});
      rst = 1'b1;
      idle(3);
      chk("rstc_valid", {31'd0, o_valid}, 0);

      // clear and ack together in DONE
      press(8);
      q2.push_back(3);
      press(11);
      wait_done(2);
      kv = 1'b1; kc = 2'd0; kf = 2'd3; ack = 1'b1;
      @(posedge clk); #1;
      kv = 1'b0; ack = 1'b0;
      chk("clrack_valid", {31'd0, o_valid}, 0);
      chk("clrack_rej", {31'd0, o_rej}, 0);
      chk("clrack_cnt", {29'd0, o_cnt}, 0);

      // digit on the ack cycle is rejected, not applied
      press(2);
      q2.push_back(7);
      press(11);
      wait_done(2);
      kv = 1'b1; kc = 2'd0; kf = 2'd0; ack = 1'b1;
      @(posedge clk); #1;
      kv = 1'b0; ack = 1'b0;
      chk("ackkey_rej", {31'd0, o_rej}, 1);
      chk("ackkey_cnt", {29'd0, o_cnt}, 0);
      chk("ackkey_valid", {31'd0, o_valid}, 0);

      // four-digit instance: 9876
      sel = 1'b1;
      do_reset();
      press(10); press(6); press(2); press(9);
      chk("bcd4", {16'd0, o_bcd}, {16'd0, eb(16'h9876)});
      chk("cnt4", {29'd0, o_cnt}, 4);
      q4.push_back(9876);
      press(11);
      wait_done(4);
      do_ack();
      chk("ack4_valid", {31'd0, o_valid}, 0);

      idle(3);
      chk("q2_empty", q2.size(), 0);
      chk("q4_empty", q4.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/module_operando.md
Name: module_operando

Overview:
- Keypad operand entry block for the multiplier front end.
- Takes each registered 4x4 keypad event (column and row codes plus a ready strobe) and decodes it to a digit or command.
- Accumulates up to N_DIGITS decimal digits and supports clear and backspace.
- On enter, converts the BCD entry to binary over several cycles and presents it with a valid/ack handshake to the multiplier datapath.

Parameters:
- N_DIGITS, 2: maximum decimal digits per operand (1..4).
- OUT_W, $clog2(10**N_DIGITS): binary operand width (7 for the default).
- LED_INV, 1: when 1, bcd_o is driven bit-inverted for the active-low board LEDs. All other outputs are never inverted.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-low.
- key_valid_i  in  1  one-cycle strobe; the key codes below are valid on this cycle.
- key_codc_i  in  2  column code of the pressed key.
- key_codf_i  in  2  row code of the pressed key.
- operand_ack_i  in  1  consumer has taken the operand.
- operand_o  out  OUT_W  binary operand; stable while operand_valid_o=1.
- operand_valid_o  out  1  operand available (level signal).
- bcd_o  out  4*N_DIGITS  digits entered so far, right-aligned, least significant digit in [3:0].
- digit_count_o  out  $clog2(N_DIGITS+1)  number of digits entered.
- busy_o  out  1  high during CONVERT.
- key_rej_o  out  1  one-cycle pulse when a key is ignored.

Behaviour:
- Key position pos = {codc, codf}.
- Digit decode: pos 0→1, 1→4, 2→7, 4→2, 5→5, 6→8, 8→3, 9→6, 10→9, 7→0.
- Command decode: pos 3 ('*') = CLEAR; pos 11 ('#') = ENTER; pos 12 ('A') = BACKSPACE; pos 13..15 = no function (rejected).
- Reset (rst=0 at a clk edge): state ENTRY, all digits 0, count 0, accumulator 0, operand_o 0, operand_valid_o 0, busy_o 0, key_rej_o 0. Reset mid-CONVERT or mid-DONE aborts with no operand delivered.
- Keys are sampled only when key_valid_i=1. All outputs are registered and update at the same edge that samples the key.
- State ENTRY:
  - Digit with count<N_DIGITS: bcd shifts left 4 bits, the new digit goes into [3:0], count+1.
  - Digit with count=N_DIGITS: ignored, key_rej_o pulses.
  - BACKSPACE with count>0: bcd shifts right 4 bits (zero fill), count-1. With count=0: rejected.
  - ENTER with count>0: go to CONVERT, index=N_DIGITS-1, accumulator 0, busy_o=1. With count=0: rejected.
  - CLEAR: digits and count go to 0; stay in ENTRY.
- State CONVERT:
  - Each cycle: acc <= acc*10 + digit[index], index-1. Width is OUT_W with no truncation, since the maximum is 10**N_DIGITS-1.
  - After exactly N_DIGITS cycles: operand_o <= acc, operand_valid_o=1, busy_o=0, go to DONE. Total latency is N_DIGITS+1 edges from the ENTER sample to operand_valid_o high.
  - Digits, ENTER and BACKSPACE are rejected with a key_rej_o pulse.
  - CLEAR aborts: clears everything, returns to ENTRY, busy_o=0, no valid asserted.
- State DONE:
  - operand_valid_o stays high until operand_ack_i=1. On ack: valid 0, digits and count cleared, go to ENTRY.
  - Digits, ENTER and BACKSPACE are rejected.
  - CLEAR behaves like ack: drops valid and returns to ENTRY.
  - operand_ack_i outside DONE is ignored.
- Priority on the same cycle: rst > CLEAR > operand_ack_i > other key. A key other than CLEAR arriving on the ack cycle is rejected; it is not applied to the new entry.
- bcd_o and digit_count_o stay frozen through CONVERT and DONE for display. bcd_o follows LED_INV.

Decomposition:
- Shared package pkg_teclado holds:
  - the key_kind_t enum (DIGIT, CLEAR, ENTER, BSPC, NONE);
  - the position localparams (P_STAR=3, P_HASH=11, P_A=12);
  - the state_t enum (ENTRY, CONVERT, DONE).
- One combinational sub-module, module_tecla_dec, maps pos to {kind, digit[3:0]}. It is reused by later keypad blocks.

Test Plan:
- N_DIGITS=2, keys pos4, pos9, pos11 → bcd_o 0x26 after the second key; busy_o for 2 cycles; then operand_o=26, operand_valid_o=1. Ack → valid 0, count 0.
- Keys pos10, pos10, pos10 → third key gives a key_rej_o pulse and bcd_o stays 0x99. ENTER → operand_o=99.
- Keys pos0, pos1, then pos12 (BACKSPACE) → bcd_o 0x01, count 1. ENTER → operand_o=1.
- ENTER with count 0, and key pos14 → key_rej_o pulse each, state stays ENTRY, outputs unchanged.
- ENTER, then pos3 (CLEAR) on the first CONVERT cycle → busy_o 0, no operand_valid_o, bcd_o 0. Repeat with rst=0 mid-CONVERT → all outputs at reset values.
- In DONE, pos3 and operand_ack_i on the same cycle → clear wins, valid drops, state ENTRY. With N_DIGITS=4, keys 9,8,7,6 then ENTER → operand_o=9876 after 5 edges.
